// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage -- execute stage of the 5-stage ARM pipeline.
//
// Selects forwarded operands, builds Val2 (rotated immediate, memory offset
// or barrel-shifted Rm), runs the ALU and registers the result into the
// EXE/MEM boundary. Also owns the NZCV status register. The whole stage
// holds while freeze is high (memory-side SRAM not ready).
//
// Ports:
//   clk, rst               clock (rising edge), async active-low reset
//   freeze                 hold EXE/MEM register and status
//   wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm, exe_cmd, shift_operand,
//   val_rn, val_rm, dest_in, pc_in, signed_imm_24   ID/EXE inputs
//   sel_src1, sel_src2     forwarding selects (01 mem_fwd, 10 wb_fwd)
//   mem_fwd, wb_fwd        forwarded values
//   wb_en, mem_r_en, mem_w_en, alu_result, rm_val, dest   EXE/MEM register
//   status                 NZCV register {N,Z,C,V}
//   branch_address         combinational pc_in + sext(signed_imm_24) << 2
// ---------------------------------------------------------------------------
module exe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic             wb_en_in,
   input  logic             mem_r_en_in,
   input  logic             mem_w_en_in,
   input  logic             s_in,
   input  logic             imm,
   input  logic [3:0]       exe_cmd,
   input  logic [11:0]      shift_operand,
   input  logic [WIDTH-1:0] val_rn,
   input  logic [WIDTH-1:0] val_rm,
   input  logic [1:0]       sel_src1,
   input  logic [1:0]       sel_src2,
   input  logic [WIDTH-1:0] mem_fwd,
   input  logic [WIDTH-1:0] wb_fwd,
   input  logic [3:0]       dest_in,
   input  logic [WIDTH-1:0] pc_in,
   input  logic [23:0]      signed_imm_24,
   output logic             wb_en,
   output logic             mem_r_en,
   output logic             mem_w_en,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] rm_val,
   output logic [3:0]       dest,
   output logic [3:0]       status,
   output logic [WIDTH-1:0] branch_address
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   localparam logic [5:0] W6 = 6'(WIDTH);

   logic [WIDTH-1:0] op1, fwd_rm, val2;
   logic [WIDTH-1:0] imm_zx, imm_rot, rm_shift;
   logic [4:0]       rot_amt, sh_amt;
   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   sum;
   logic             c_new, v_new;

   // ---- operand forwarding -------------------------------------------------
   always_comb begin
      case (sel_src1)
         2'b01:   op1 = mem_fwd;
         2'b10:   op1 = wb_fwd;
         default: op1 = val_rn;
      endcase
      case (sel_src2)
         2'b01:   fwd_rm = mem_fwd;
         2'b10:   fwd_rm = wb_fwd;
         default: fwd_rm = val_rm;
      endcase
   end

   // ---- Val2 generation ----------------------------------------------------
   assign imm_zx  = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
   assign rot_amt = {shift_operand[11:8], 1'b0};
   assign sh_amt  = shift_operand[11:7];

   // A shift by the full width yields zero, so amount 0 rotates to itself.
   assign imm_rot = (imm_zx >> rot_amt) | (imm_zx << (W6 - {1'b0, rot_amt}));

   always_comb begin
      case (shift_operand[6:5])
         2'b00:   rm_shift = fwd_rm << sh_amt;
         2'b01:   rm_shift = fwd_rm >> sh_amt;
         2'b10:   rm_shift = WIDTH'($signed(fwd_rm) >>> sh_amt);
         default: rm_shift = (fwd_rm >> sh_amt) | (fwd_rm << (W6 - {1'b0, sh_amt}));
      endcase
   end

   always_comb begin
      if (imm)
         val2 = imm_rot;
      else if (mem_r_en_in || mem_w_en_in)
         val2 = {{(WIDTH-12){1'b0}}, shift_operand};
      else
         val2 = rm_shift;
   end

   // ---- ALU ----------------------------------------------------------------
   // Carry-in always comes from the registered flag, never this cycle's.
   always_comb begin
      sum   = '0;
      res   = '0;
      c_new = status[1];
      v_new = status[0];
      case (exe_cmd)
         CMD_MOV: res = val2;
         CMD_MVN: res = ~val2;
         CMD_ADD, CMD_ADC: begin
            sum   = {1'b0, op1} + {1'b0, val2} +
                    {{WIDTH{1'b0}}, (exe_cmd == CMD_ADC) & status[1]};
            res   = sum[WIDTH-1:0];
            c_new = sum[WIDTH];
            v_new = (op1[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
         end
         CMD_SUB, CMD_SBC: begin
            // Bit WIDTH of the 33-bit difference is the borrow; C is its inverse.
            sum   = {1'b0, op1} - {1'b0, val2} -
                    {{WIDTH{1'b0}}, (exe_cmd == CMD_SBC) & ~status[1]};
            res   = sum[WIDTH-1:0];
            c_new = ~sum[WIDTH];
            v_new = (op1[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
         end
         CMD_AND: res = op1 & val2;
         CMD_ORR: res = op1 | val2;
         CMD_EOR: res = op1 ^ val2;
         default: res = '0;
      endcase
   end

   // ---- status register ----------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         status <= 4'b0000;
      else if (s_in && !freeze)
         status <= {res[WIDTH-1], (res == '0), c_new, v_new};
   end

   // ---- EXE/MEM register ---------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en      <= 1'b0;
         mem_r_en   <= 1'b0;
         mem_w_en   <= 1'b0;
         alu_result <= '0;
         rm_val     <= '0;
         dest       <= 4'd0;
      end else if (!freeze) begin
         wb_en      <= wb_en_in;
         mem_r_en   <= mem_r_en_in;
         mem_w_en   <= mem_w_en_in;
         alu_result <= res;
         rm_val     <= fwd_rm;
         dest       <= dest_in;
      end
   end

   // ---- branch target ------------------------------------------------------
   assign branch_address = pc_in + {{(WIDTH-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

   logic        clk, rst, freeze;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm;
   logic [3:0]  exe_cmd, dest_in;
   logic [11:0] shift_operand;
   logic [31:0] val_rn, val_rm, mem_fwd, wb_fwd, pc_in;
   logic [1:0]  sel_src1, sel_src2;
   logic [23:0] signed_imm_24;
   logic        wb_en, mem_r_en, mem_w_en;
   logic [31:0] alu_result, rm_val, branch_address;
   logic [3:0]  dest, status;

   int n_cmp = 0;
   int n_bad = 0;

   exe_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .s_in(s_in), .imm(imm), .exe_cmd(exe_cmd), .shift_operand(shift_operand),
      .val_rn(val_rn), .val_rm(val_rm), .sel_src1(sel_src1), .sel_src2(sel_src2),
      .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .dest_in(dest_in), .pc_in(pc_in),
      .signed_imm_24(signed_imm_24),
      .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .alu_result(alu_result), .rm_val(rm_val), .dest(dest), .status(status),
      .branch_address(branch_address)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] ror1(input logic [31:0] x);
      return (x >> 1) | ((x & 32'd1) << 31);
   endfunction

   function automatic logic [31:0] m_val2(input logic im, input logic memop,
                                          input logic [11:0] so, input logic [31:0] rm);
      logic [31:0] v;
      longint      t;
      int          amt;
      if (im) begin
         v = {24'd0, so[7:0]};
         for (int k = 0; k < 2 * int'(so[11:8]); k++) v = ror1(v);
         return v;
      end
      if (memop) return {20'd0, so};
      amt = int'(so[11:7]);
      case (so[6:5])
         2'b00: begin t = longint'(rm) * (longint'(1) << amt); v = t[31:0]; end
         2'b01: begin t = longint'(rm) / (longint'(1) << amt); v = t[31:0]; end
         2'b10: begin t = longint'($signed(rm)) >>> amt; v = t[31:0]; end
         default: begin
            v = rm;
            for (int k = 0; k < amt; k++) v = ror1(v);
         end
      endcase
      return v;
   endfunction

   // returns {N,Z,C,V,result}
   function automatic logic [35:0] m_alu(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] st);
      longint ua, ub, sa, sb, r, sr, cin;
      logic c, v;
      logic [31:0] res;
      ua = longint'(a); ub = longint'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      cin = longint'(st[1]);
      c = st[1]; v = st[0]; r = 0; sr = 0;
      case (cmd)
         4'd1: r = ub;
         4'd9: r = ub ^ 64'hFFFF_FFFF;
         4'd2, 4'd3: begin
            r  = ua + ub + ((cmd == 4'd3) ? cin : 0);
            sr = sa + sb + ((cmd == 4'd3) ? cin : 0);
            c  = (r > 64'sd4294967295);
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            r  = ua - ub - ((cmd == 4'd5) ? (1 - cin) : 0);
            sr = sa - sb - ((cmd == 4'd5) ? (1 - cin) : 0);
            c  = (ua >= ub + ((cmd == 4'd5) ? (1 - cin) : 0));
            v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
         end
         4'd6: r = ua & ub;
         4'd7: r = ua | ub;
         4'd8: r = ua ^ ub;
         default: r = 0;
      endcase
      res = r[31:0];
      return {res[31], (res == 32'd0), c, v, res};
   endfunction

   logic        m_wb = 0, m_mr = 0, m_mw = 0;
   logic [31:0] m_alu_q = 0, m_rm = 0;
   logic [3:0]  m_dest = 0, m_status = 0;

   function automatic logic [31:0] m_sel(input logic [1:0] s, input logic [31:0] reg_v);
      return (s == 2'b01) ? mem_fwd : (s == 2'b10) ? wb_fwd : reg_v;
   endfunction

   always @(posedge clk or negedge rst) begin
      logic [35:0] o;
      logic [31:0] a, rmv;
      if (!rst) begin
         m_wb <= 0; m_mr <= 0; m_mw <= 0;
         m_alu_q <= 0; m_rm <= 0; m_dest <= 0; m_status <= 0;
      end else if (!freeze) begin
         a   = m_sel(sel_src1, val_rn);
         rmv = m_sel(sel_src2, val_rm);
         o   = m_alu(exe_cmd, a, m_val2(imm, mem_r_en_in | mem_w_en_in, shift_operand, rmv), m_status);
         m_wb <= wb_en_in; m_mr <= mem_r_en_in; m_mw <= mem_w_en_in;
         m_alu_q <= o[31:0]; m_rm <= rmv; m_dest <= dest_in;
         if (s_in) m_status <= o[35:32];
      end
   end

   function automatic logic [31:0] m_branch(input logic [31:0] pc, input logic [23:0] off);
      longint o;
      o = longint'(off);
      if (o >= 64'sd8388608) o = o - 64'sd16777216;
      o = longint'(pc) + o * 4;
      return o[31:0];
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("wb_en",      {31'd0, wb_en},    {31'd0, m_wb});
      chk("mem_r_en",   {31'd0, mem_r_en}, {31'd0, m_mr});
      chk("mem_w_en",   {31'd0, mem_w_en}, {31'd0, m_mw});
      chk("alu_result", alu_result,        m_alu_q);
      chk("rm_val",     rm_val,            m_rm);
      chk("dest",       {28'd0, dest},     {28'd0, m_dest});
      chk("status",     {28'd0, status},   {28'd0, m_status});
      chk("branch",     branch_address,    m_branch(pc_in, signed_imm_24));
   end

   // ---------------- stimulus ----------------
   task automatic clr();
      wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_in = 0; imm = 0;
      exe_cmd = 0; shift_operand = 0; val_rn = 0; val_rm = 0;
      sel_src1 = 0; sel_src2 = 0; mem_fwd = 0; wb_fwd = 0; dest_in = 0;
      pc_in = 0; signed_imm_24 = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   typedef struct {
      logic [3:0]  cmd;
      logic        im;
      logic [11:0] so;
      logic [31:0] rn;
      logic [31:0] rm;
      logic        mr;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{4'h6, 1'b0, 12'h000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0}; // AND
      tbl[1] = '{4'h7, 1'b0, 12'h000, 32'h1200_0000, 32'h0000_0034, 1'b0}; // ORR
      tbl[2] = '{4'h8, 1'b0, 12'h000, 32'hFFFF_0000, 32'hFF00_FF00, 1'b0}; // EOR
      tbl[3] = '{4'h9, 1'b1, 12'h0FF, 32'h0,         32'h0,         1'b0}; // MVN
      tbl[4] = '{4'hF, 1'b0, 12'h000, 32'h5,         32'h5,         1'b0}; // undefined
      tbl[5] = '{4'h1, 1'b0, 12'h460, 32'h0,         32'h0000_00AB, 1'b0}; // ROR #8
      tbl[6] = '{4'h1, 1'b0, 12'hFA0, 32'h0,         32'h8000_0000, 1'b0}; // LSR #31
      tbl[7] = '{4'h1, 1'b0, 12'hF80, 32'h0,         32'h3,         1'b0}; // LSL #31
      tbl[8] = '{4'h5, 1'b0, 12'h000, 32'h0,         32'h1,         1'b0}; // SBC 0-1
      tbl[9] = '{4'h2, 1'b0, 12'h004, 32'h200,       32'h0,         1'b1}; // LDR offset

      freeze = 0;
      clr();
      rst = 1;
      #1 rst = 0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset alu", alu_result, 32'h0);
      chk("reset status", {28'd0, status}, 32'h0);
      rst = 1;

      // ADD 5 + #3
      clr(); exe_cmd = 4'h2; val_rn = 5; imm = 1; shift_operand = 12'h003; s_in = 1;
      tick();
      chk("add alu", alu_result, 32'd8);
      chk("add status", {28'd0, status}, 32'h0);

      // MOV rotated immediate
      clr(); exe_cmd = 4'h1; imm = 1; shift_operand = 12'h4FF; s_in = 1;
      tick();
      chk("mov rot alu", alu_result, 32'hFF00_0000);
      chk("mov rot status", {28'd0, status}, 32'h8);

      // SUB equal operands
      clr(); exe_cmd = 4'h4; val_rn = 7; val_rm = 7; s_in = 1;
      tick();
      chk("sub eq alu", alu_result, 32'h0);
      chk("sub eq status", {28'd0, status}, 32'h6);

      // SBC 7-3 with C=1
      clr(); exe_cmd = 4'h5; val_rn = 7; val_rm = 3; s_in = 1;
      tick();
      chk("sbc alu", alu_result, 32'd4);
      chk("sbc status", {28'd0, status}, 32'h2);

      // signed overflow
      clr(); exe_cmd = 4'h2; val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001; s_in = 1;
      tick();
      chk("ovf alu", alu_result, 32'h8000_0000);
      chk("ovf status", {28'd0, status}, 32'h9);

      // ASR #4, no flag update
      clr(); exe_cmd = 4'h1; val_rm = 32'h8000_0000; shift_operand = 12'h240;
      tick();
      chk("asr alu", alu_result, 32'hF800_0000);
      chk("asr status held", {28'd0, status}, 32'h9);

      // STR with forwarded base and store data
      clr(); exe_cmd = 4'h2; mem_w_en_in = 1; sel_src1 = 2'b01; mem_fwd = 32'h100;
      shift_operand = 12'h010; sel_src2 = 2'b10; wb_fwd = 32'hAB; val_rm = 32'h55; dest_in = 3;
      tick();
      chk("str addr", alu_result, 32'h110);
      chk("str data", rm_val, 32'hAB);
      chk("str mem_w_en", {31'd0, mem_w_en}, 32'd1);

      // freeze for 3 cycles while inputs change
      freeze = 1;
      clr(); exe_cmd = 4'h2; val_rn = 1; imm = 1; shift_operand = 12'h001; s_in = 1;
      wb_en_in = 1; dest_in = 5;
      tick(); val_rn = 9;
      tick(); val_rn = 20;
      tick();
      chk("frz alu", alu_result, 32'h110);
      chk("frz rm_val", rm_val, 32'hAB);
      chk("frz status", {28'd0, status}, 32'h9);
      chk("frz wb_en", {31'd0, wb_en}, 32'd0);
      freeze = 0;
      tick();
      chk("unfrz alu", alu_result, 32'd21);
      chk("unfrz status", {28'd0, status}, 32'h0);
      chk("unfrz dest", {28'd0, dest}, 32'd5);

      // ADC chain: set carry, then consume it
      clr(); exe_cmd = 4'h2; val_rn = 32'hFFFF_FFFF; imm = 1; shift_operand = 12'h001; s_in = 1;
      tick();
      chk("carry alu", alu_result, 32'h0);
      chk("carry status", {28'd0, status}, 32'h6);
      clr(); exe_cmd = 4'h3; val_rn = 1; imm = 1; shift_operand = 12'h001; s_in = 1;
      tick();
      chk("adc alu", alu_result, 32'd3);
      chk("adc status", {28'd0, status}, 32'h0);

      // subtract overflow
      clr(); exe_cmd = 4'h4; val_rn = 32'h8000_0000; imm = 1; shift_operand = 12'h001; s_in = 1;
      tick();
      chk("subovf alu", alu_result, 32'h7FFF_FFFF);
      chk("subovf status", {28'd0, status}, 32'h3);

      // model-checked sweep
      for (int i = 0; i < 10; i++) begin
         clr();
         exe_cmd = tbl[i].cmd; imm = tbl[i].im; shift_operand = tbl[i].so;
         val_rn = tbl[i].rn; val_rm = tbl[i].rm; mem_r_en_in = tbl[i].mr;
         s_in = 1; wb_en_in = 1; dest_in = 4'(i);
         tick();
      end
      chk("ldr addr", alu_result, 32'h204);

      // reset asserted in the middle of a freeze
      clr(); exe_cmd = 4'h2; val_rn = 3; imm = 1; shift_operand = 12'h004; wb_en_in = 1; s_in = 1;
      tick();
      chk("pre-rst alu", alu_result, 32'd7);
      freeze = 1;
      tick();
      #1 rst = 0;
      #1;
      chk("rst-frz alu", alu_result, 32'h0);
      chk("rst-frz wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst-frz status", {28'd0, status}, 32'h0);
      rst = 1;
      tick();
      chk("post-rst frz alu", alu_result, 32'h0);
      freeze = 0;
      tick();
      chk("post-rst load", alu_result, 32'd7);

      // branch target
      clr(); pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE;
      #1 chk("branch back", branch_address, 32'hF8);
      pc_in = 32'hFFFF_FFFC; signed_imm_24 = 24'h000002;
      #1 chk("branch wrap", branch_address, 32'h4);

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
